// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding and default timing parameters shared by the hazard
// controller and its load-use detector.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

  localparam int MDU_LAT_DEF      = 4;
  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int REG_W_DEF        = 5;

  // Down-counters never wrap; small configurations keep a fixed 2-bit counter.
  function automatic int cnt_w(input int p);
    return (p <= 4) ? 2 : $clog2(p);
  endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: combinational load-use compare between the load in EX and
// the source registers of the instruction in ID.
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu
);

  logic ex_rt_nonzero;
  logic rs_match;
  logic rt_match;

  // r0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign ex_rt_nonzero = (ex_rt != '0);
  assign rs_match      = (ex_rt == id_rs);
  assign rt_match      = id_uses_rt && (ex_rt == id_rt);
  assign lu            = ex_mem_read && ex_rt_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the IF/ID, ID/EX and PC controls.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT      = MDU_LAT_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int REG_W        = REG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             ID_MduStart,
  input  logic             ID_BranchTkn,
  input  logic             ID_Jump,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             ifid_flushB,
  output logic             idex_bubble,
  output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  localparam int MCW = cnt_w(MDU_LAT);
  localparam int FCW = cnt_w(FLUSH_CYCLES);

  localparam logic [MCW-1:0] MDU_INIT   = MCW'(MDU_LAT - 1);
  localparam logic [MCW-1:0] MDU_ONE    = MCW'(1);
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
  localparam logic [FCW-1:0] FLUSH_ONE  = FCW'(1);

  hz_state_e      state_q, state_d;
  logic [MCW-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic           redir_br_q, redir_br_d;

  logic lu;
  logic redirect_req;
  logic stall_c;
  logic flush_c;
  logic flushb_c;

  hazard_lu_detect #(
    .REG_W (REG_W)
  ) u_lu_detect (
    .id_rs       (ID_Rs),
    .id_rt       (ID_Rt),
    .id_uses_rt  (ID_UsesRt),
    .ex_mem_read (EX_MemRead),
    .ex_rt       (EX_Rt),
    .lu          (lu)
  );

  assign redirect_req = ID_BranchTkn || ID_Jump;

  always_comb begin
    state_d     = state_q;
    mdu_cnt_d   = mdu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    redir_br_d  = redir_br_q;
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    flushb_c    = 1'b0;

    case (state_q)
      RUN: begin
        // Load-use wins: the ID instruction is replayed, so its branch/jump/mdu
        // decode is not acted on until the hazard clears.
        if (lu) begin
          stall_c = 1'b1;
        end else if (redirect_req) begin
          flushb_c = ID_BranchTkn;
          flush_c  = ID_Jump && !ID_BranchTkn;
          if (FLUSH_CYCLES > 1) begin
            state_d     = REDIRECT;
            flush_cnt_d = FLUSH_INIT;
            redir_br_d  = ID_BranchTkn;
          end
        end else if (ID_MduStart) begin
          state_d   = MDU_WAIT;
          mdu_cnt_d = MDU_INIT;
        end
      end

      MDU_WAIT: begin
        stall_c   = 1'b1;
        mdu_cnt_d = mdu_cnt_q - MDU_ONE;
        if (mdu_cnt_q <= MDU_ONE) begin
          state_d = RUN;
        end
      end

      REDIRECT: begin
        flushb_c    = redir_br_q;
        flush_c     = !redir_br_q;
        flush_cnt_d = flush_cnt_q - FLUSH_ONE;
        if (flush_cnt_q <= FLUSH_ONE) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      mdu_cnt_q   <= '0;
      flush_cnt_q <= '0;
      redir_br_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      redir_br_q  <= redir_br_d;
    end
  end

  // Outputs depend on live inputs, so they must be forced low while reset is held.
  assign pc_stall    = stall_c && !reset;
  assign ifid_stall  = stall_c && !reset;
  assign idex_bubble = stall_c && !reset;
  assign ifid_flush  = flush_c && !reset;
  assign ifid_flushB = flushb_c && !reset;
  assign ctrl_state  = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (ifid_stall && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
    if ((ifid_flush || ifid_flushB) && (perf_flush_cnt_q != 32'hFFFF_FFFF)) begin
      perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random stimulus for hazard_ctrl,
// checked against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int MDU_LAT      = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int REG_W        = 5;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRt;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_Rt;
  logic             ID_MduStart;
  logic             ID_BranchTkn;
  logic             ID_Jump;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             ifid_flushB;
  logic             idex_bubble;
  logic [1:0]       ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      perf_stall_cnt;
  logic [31:0]      perf_flush_cnt;
`endif

  int total;
  int bad;

  // Reference model: remaining stall / flush cycles still owed after the current one.
  int m_stall_left;
  int m_flush_left;
  bit m_flush_br;
  int m_perf_stall;
  int m_perf_flush;

  logic [4:0] obs;
  assign obs = {pc_stall, ifid_stall, ifid_flush, ifid_flushB, idex_bubble};

  hazard_ctrl #(
    .MDU_LAT      (MDU_LAT),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .REG_W        (REG_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_UsesRt    (ID_UsesRt),
    .EX_MemRead   (EX_MemRead),
    .EX_Rt        (EX_Rt),
    .ID_MduStart  (ID_MduStart),
    .ID_BranchTkn (ID_BranchTkn),
    .ID_Jump      (ID_Jump),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .ifid_flushB  (ifid_flushB),
    .idex_bubble  (idex_bubble),
    .ctrl_state   (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit lu_f();
    return EX_MemRead && (EX_Rt != 0) &&
           ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  endfunction

  // {pc_stall, ifid_stall, ifid_flush, ifid_flushB, idex_bubble}
  function automatic logic [4:0] exp_out();
    if (m_stall_left > 0) return 5'b11001;
    if (m_flush_left > 0) return m_flush_br ? 5'b00010 : 5'b00100;
    if (lu_f())           return 5'b11001;
    if (ID_BranchTkn)     return 5'b00010;
    if (ID_Jump)          return 5'b00100;
    return 5'b00000;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_stall_left > 0) return 2'd1;
    if (m_flush_left > 0) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_stall_left = 0;
    m_flush_left = 0;
    m_flush_br   = 1'b0;
    m_perf_stall = 0;
    m_perf_flush = 0;
  endtask

  task automatic model_advance();
    logic [4:0] e;
    e = exp_out();
    if (e[3]) m_perf_stall++;
    if (e[2] || e[1]) m_perf_flush++;
    if (m_stall_left > 0) begin
      m_stall_left--;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (!lu_f()) begin
      if (ID_BranchTkn || ID_Jump) begin
        m_flush_left = FLUSH_CYCLES - 1;
        m_flush_br   = ID_BranchTkn;
      end else if (ID_MduStart) begin
        m_stall_left = MDU_LAT - 1;
      end
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic mdu,
                       input logic br, input logic jmp);
    EX_MemRead   = mr;
    EX_Rt        = ert;
    ID_Rs        = rs;
    ID_Rt        = rt;
    ID_UsesRt    = urt;
    ID_MduStart  = mdu;
    ID_BranchTkn = br;
    ID_Jump      = jmp;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 5'b00000);
    end
    total++;
    if (ctrl_state !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %0d expected 0", ctrl_state);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL post_reset_idle: got %b expected %b", obs, 5'b00000);
    end
    end_cycle();
  endtask

  task automatic test_load_use();
    // cycle 0: rs match; cycle 1: hazard gone; cycle 2: rt match with uses_rt; cycle 3: rt match but unused
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(1'b1, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        1: drive(1'b0, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        2: drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        default: drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      total++;
      if (obs !== exp_out()) begin
        bad++;
        $display("[TB] FAIL load_use[%0d]: got %b expected %b", c, obs, exp_out());
      end
      total++;
      if (obs !== ((c == 0 || c == 2) ? 5'b11001 : 5'b00000)) begin
        bad++;
        $display("[TB] FAIL load_use_const[%0d]: got %b", c, obs);
      end
      end_cycle();
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL r0_exempt: got %b expected %b", obs, 5'b00000);
    end
    end_cycle();
  endtask

  task automatic test_mdu();
    logic [1:0] st_exp [5];
    st_exp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, (c == 0), 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (ctrl_state !== st_exp[c] || ifid_stall !== (c >= 1 && c <= 3)) begin
        bad++;
        $display("[TB] FAIL mdu[%0d]: state %0d stall %b, expected state %0d",
                 c, ctrl_state, ifid_stall, st_exp[c]);
      end
      total++;
      if (obs !== exp_out()) begin
        bad++;
        $display("[TB] FAIL mdu_model[%0d]: got %b expected %b", c, obs, exp_out());
      end
      end_cycle();
    end
  endtask

  task automatic test_redirect_both();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, (c == 0), (c == 0));
      @(negedge clk);
      total++;
      if (ifid_flushB !== (c < 2) || ifid_flush !== 1'b0 || ifid_stall !== 1'b0) begin
        bad++;
        $display("[TB] FAIL redirect_both[%0d]: flushB %b flush %b stall %b", c,
                 ifid_flushB, ifid_flush, ifid_stall);
      end
      total++;
      if (ctrl_state !== exp_state()) begin
        bad++;
        $display("[TB] FAIL redirect_state[%0d]: got %0d expected %0d", c, ctrl_state, exp_state());
      end
      end_cycle();
    end
  endtask

  task automatic test_lu_vs_branch();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      else        drive(1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (obs !== ((c == 0) ? 5'b11001 : 5'b00000) || ctrl_state !== 2'd0) begin
        bad++;
        $display("[TB] FAIL lu_vs_branch[%0d]: got %b state %0d", c, obs, ctrl_state);
      end
      end_cycle();
    end
  endtask

  task automatic test_reset_mid_mdu();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    end_cycle();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    end_cycle();
    total++;
    if (ctrl_state !== 2'd1 || ifid_stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_mdu_pre: state %0d stall %b, expected 1 1", ctrl_state, ifid_stall);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== 5'b00000 || ctrl_state !== 2'd0) begin
      bad++;
      $display("[TB] FAIL mid_mdu_reset: got %b state %0d expected 00000 state 0", obs, ctrl_state);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if (obs !== 5'b00000 || ctrl_state !== 2'd0) begin
      bad++;
      $display("[TB] FAIL mid_mdu_release: got %b state %0d expected 00000 state 0", obs, ctrl_state);
    end
    end_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 19) < 3), ($urandom_range(0, 19) < 3));
      @(negedge clk);
      total++;
      if (obs !== exp_out()) begin
        bad++;
        $display("[TB] FAIL random_out[%0d]: got %b expected %b", c, obs, exp_out());
      end
      total++;
      if (ctrl_state !== exp_state()) begin
        bad++;
        $display("[TB] FAIL random_state[%0d]: got %0d expected %0d", c, ctrl_state, exp_state());
      end
      total++;
      if ((ifid_flush && ifid_flushB) || ((ifid_flush || ifid_flushB) && ifid_stall)) begin
        bad++;
        $display("[TB] FAIL random_exclusive[%0d]: got %b", c, obs);
      end
      end_cycle();
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (perf_stall_cnt !== 32'(m_perf_stall) || perf_flush_cnt !== 32'(m_perf_flush)) begin
      bad++;
      $display("[TB] FAIL perf_counts: got %0d/%0d expected %0d/%0d",
               perf_stall_cnt, perf_flush_cnt, m_perf_stall, m_perf_flush);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    test_reset();
    test_load_use();
    test_r0();
    test_mdu();
    test_redirect_both();
    test_lu_vs_branch();
    test_reset_mid_mdu();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
